// File: rtl/barret_pkg.sv
// Shared constants and helpers for the Barrett reducer family.
package barret_pkg;

    localparam int Q_DEFAULT = 367;

    function automatic int res_width(input int q);
        return $clog2(q);
    endfunction

    // floor(2^k / q), evaluated in 64 bits so moduli up to ~2^31 stay exact
    function automatic longint unsigned barret_mu(input int q, input int k);
        longint unsigned one;
        one = 64'd1;
        return (one << k) / longint'(q);
    endfunction

endpackage

// File: rtl/barret_cond_sub.sv
// Final Barrett correction: folds a residue in [0, 3Q) down to [0, Q).
module barret_cond_sub
    import barret_pkg::*;
#(
    parameter int Q = Q_DEFAULT,
    parameter int W = res_width(Q)
) (
    input  logic [W+1:0] i_r2,
    output logic [W-1:0] o_r
);

    localparam int R_W = W + 2;
    localparam logic [R_W-1:0] Q1 = R_W'(Q);
    localparam logic [R_W-1:0] Q2 = R_W'(2 * Q);

    logic [R_W-1:0] w_res;

    always_comb begin
        w_res = i_r2;
        if (i_r2 >= Q2) begin
            w_res = i_r2 - Q2;
        end else if (i_r2 >= Q1) begin
            w_res = i_r2 - Q1;
        end
    end

    assign o_r = W'(w_res);

endmodule

// File: rtl/barret_reduce_pipe.sv
// Three-stage Barrett reducer (dout_r = din_a mod Q) with valid/ready flow
// control on both sides; sustains one result per cycle under backpressure.
module barret_reduce_pipe
    import barret_pkg::*;
#(
    parameter int Q    = Q_DEFAULT,
    parameter int W    = res_width(Q),
    parameter int IN_W = 2 * W - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [IN_W-1:0] din_a,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [W-1:0]    dout_r,
    output logic            busy
);

    localparam int              K    = 2 * W;
    localparam longint unsigned MU   = barret_mu(Q, K);
    localparam int              MU_W = $clog2(MU + 1);
    localparam int              P_W  = IN_W + MU_W;
    localparam int              R_W  = W + 2;

    localparam logic [P_W-1:0] MU_P = P_W'(MU);
    localparam logic [P_W-1:0] Q_P  = P_W'(Q);

    if (Q < 3 || (Q & (Q - 1)) == 0) begin : g_bad_q
        $error("barret_reduce_pipe: Q must be >= 3 and not a power of two");
    end

    logic            r_v1;
    logic            r_v2;
    logic            r_dout_valid;
    logic [IN_W-1:0] r_x1;
    logic [P_W-1:0]  r_p1;
    logic [R_W-1:0]  r_r2;
    logic [W-1:0]    r_dout;

    logic            w_ready1;
    logic            w_ready2;
    logic            w_ready3;
    logic [IN_W-1:0] w_qq;
    logic [W-1:0]    w_sub;

    assign w_ready3 = !r_dout_valid || dout_ready;
    assign w_ready2 = !r_v2 || w_ready3;
    assign w_ready1 = !r_v1 || w_ready2;

    // q*Q never exceeds x1, so the IN_W-bit product and difference are exact
    assign w_qq = IN_W'((r_p1 >> K) * Q_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_x1 <= '0;
            r_p1 <= '0;
        end else if (w_ready1) begin
            r_v1 <= din_valid;
            if (din_valid) begin
                r_x1 <= din_a;
                r_p1 <= P_W'(din_a) * MU_P;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_r2 <= '0;
        end else if (w_ready2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_r2 <= R_W'(r_x1 - w_qq);
            end
        end
    end

    barret_cond_sub #(
        .Q (Q),
        .W (W)
    ) u_cond_sub (
        .i_r2 (r_r2),
        .o_r  (w_sub)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
        end else if (w_ready3) begin
            r_dout_valid <= r_v2;
            if (r_v2) begin
                r_dout <= w_sub;
            end
        end
    end

    assign din_ready  = w_ready1;
    assign dout_valid = r_dout_valid;
    assign dout_r     = r_dout;
    assign busy       = r_v1 | r_v2 | r_dout_valid;

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Scoreboard bench for barret_reduce_pipe at Q=367 and Q=3329.
module tb_barret_reduce_pipe;

    localparam int QA = 367;
    localparam int WA = 9;
    localparam int INA = 17;
    localparam int QB = 3329;
    localparam int WB = 12;
    localparam int INB = 23;

    logic clk;
    logic rst_n;

    logic           a_din_valid, a_din_ready, a_dout_valid, a_dout_ready, a_busy;
    logic [INA-1:0] a_din_a;
    logic [WA-1:0]  a_dout_r;
    logic           b_din_valid, b_din_ready, b_dout_valid, b_dout_ready, b_busy;
    logic [INB-1:0] b_din_a;
    logic [WB-1:0]  b_dout_r;

    typedef struct {
        int unsigned val;
        int unsigned cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int unsigned cyc;
    int          n_checks;
    int          n_pass;
    bit          chk_lat_a;
    bit          bp_a;
    bit          bp_b;
    int          hold_lo;

    barret_reduce_pipe dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (a_din_valid),
        .din_ready  (a_din_ready),
        .din_a      (a_din_a),
        .dout_valid (a_dout_valid),
        .dout_ready (a_dout_ready),
        .dout_r     (a_dout_r),
        .busy       (a_busy)
    );

    barret_reduce_pipe #(.Q(QB), .W(WB), .IN_W(INB)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (b_din_valid),
        .din_ready  (b_din_ready),
        .din_a      (b_din_a),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready),
        .dout_r     (b_dout_r),
        .busy       (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Consumer-side ready generators
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!bp_a) begin
                a_dout_ready = 1'b1;
            end else if (hold_lo > 0) begin
                a_dout_ready = 1'b0;
                hold_lo--;
            end else begin
                a_dout_ready = 1'($urandom_range(0, 1));
            end
            b_dout_ready = bp_b ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor A: value, latency, stall hold and ready/occupancy
    logic          prev_stall_a;
    logic [WA-1:0] prev_r_a;
    int            occ_a;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_n) begin
            prev_stall_a = 1'b0;
            occ_a = 0;
        end else begin
            if (prev_stall_a) begin
                chk("a_hold_valid", a_dout_valid, 1);
                chk("a_hold_data", a_dout_r, prev_r_a);
            end
            chk("a_din_ready", a_din_ready, !(occ_a == 3 && !a_dout_ready));
            if (a_dout_valid && a_dout_ready) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_spurious: output %0d with no word outstanding (t=%0t)", a_dout_r, $time);
                end else begin
                    e = q_a.pop_front();
                    chk("a_value", a_dout_r, e.val);
                    if (chk_lat_a) chk("a_latency", cyc - e.cyc, 3);
                end
            end
            occ_a = occ_a + int'(a_din_valid && a_din_ready) - int'(a_dout_valid && a_dout_ready);
            prev_stall_a = a_dout_valid && !a_dout_ready;
            prev_r_a = a_dout_r;
        end
    end

    // Monitor B
    logic          prev_stall_b;
    logic [WB-1:0] prev_r_b;
    int            occ_b;
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_n) begin
            prev_stall_b = 1'b0;
            occ_b = 0;
        end else begin
            if (prev_stall_b) chk("b_hold_data", b_dout_r, prev_r_b);
            chk("b_din_ready", b_din_ready, !(occ_b == 3 && !b_dout_ready));
            if (b_dout_valid && b_dout_ready) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_spurious: output %0d with no word outstanding (t=%0t)", b_dout_r, $time);
                end else begin
                    e = q_b.pop_front();
                    chk("b_value", b_dout_r, e.val);
                end
            end
            occ_b = occ_b + int'(b_din_valid && b_din_ready) - int'(b_dout_valid && b_dout_ready);
            prev_stall_b = b_dout_valid && !b_dout_ready;
            prev_r_b = b_dout_r;
        end
    end

    // Drivers: called at posedge+1, return at posedge+1 after the accepting edge
    task automatic send_a(input int unsigned v);
        int n;
        n = 0;
        if (v >= (32'd1 << INA)) begin
            $display("FAIL a_stim_range: din_a %0d exceeds input width", v);
            $fatal(1, "stimulus out of range");
        end
        a_din_a = INA'(v);
        a_din_valid = 1'b1;
        @(negedge clk);
        while (!a_din_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!a_din_ready) chk("a_accept_timeout", a_din_ready, 1);
        else q_a.push_back('{val: v % QA, cyc: cyc});
        @(posedge clk);
        #1;
        a_din_valid = 1'b0;
    endtask

    task automatic send_b(input int unsigned v);
        int n;
        n = 0;
        if (v >= (32'd1 << INB)) begin
            $display("FAIL b_stim_range: din_a %0d exceeds input width", v);
            $fatal(1, "stimulus out of range");
        end
        b_din_a = INB'(v);
        b_din_valid = 1'b1;
        @(negedge clk);
        while (!b_din_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!b_din_ready) chk("b_accept_timeout", b_din_ready, 1);
        else q_b.push_back('{val: v % QB, cyc: cyc});
        @(posedge clk);
        #1;
        b_din_valid = 1'b0;
    endtask

    task automatic wait_drain_a();
        int n;
        n = 0;
        while (q_a.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain", q_a.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain_b();
        int n;
        n = 0;
        while (q_b.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("b_drain", q_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int unsigned bnd_a[4] = '{367, 368, 734, 131071};
    int unsigned bnd_b[3] = '{3328, 3329, 8388607};

    initial begin
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        a_din_valid = 1'b0;
        a_din_a = '0;
        a_dout_ready = 1'b1;
        b_din_valid = 1'b0;
        b_din_a = '0;
        b_dout_ready = 1'b1;
        bp_a = 1'b0;
        bp_b = 1'b0;
        chk_lat_a = 1'b0;
        hold_lo = 0;

        #17;
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_din_ready", a_din_ready, 1);
        chk("rst_a_dout_valid", a_dout_valid, 0);
        chk("rst_a_dout_r", a_dout_r, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_din_ready", b_din_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exhaustive residue sweep, boundaries and random values, no stalls
        chk_lat_a = 1'b1;
        for (int v = 0; v < QA; v++) send_a(v);
        foreach (bnd_a[i]) send_a(bnd_a[i]);
        for (int i = 0; i < 50; i++) send_a($urandom_range(0, (1 << INA) - 1));
        wait_drain_a();

        // Random backpressure starting with a 5-cycle stall
        chk_lat_a = 1'b0;
        hold_lo = 5;
        bp_a = 1'b1;
        for (int i = 0; i < 40; i++) send_a($urandom_range(0, (1 << INA) - 1));
        wait_drain_a();
        bp_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset with three words in flight
        chk_lat_a = 1'b1;
        send_a(1000);
        send_a(2000);
        send_a(3000);
        chk("mid_busy_before", a_busy, 1);
        chk("mid_valid_before", a_dout_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout_valid", a_dout_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_dout_r", a_dout_r, 0);
        chk("mid_rst_din_ready", a_din_ready, 1);
        q_a.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", a_busy, 0);
        send_a(12345);
        send_a(777);
        wait_drain_a();

        // Second parameterisation: Q=3329
        bp_b = 1'b1;
        foreach (bnd_b[i]) send_b(bnd_b[i]);
        for (int i = 0; i < 10000; i++) send_b($urandom_range(0, (1 << INB) - 1));
        wait_drain_b();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
